// File: rtl/par2ser_pkg.sv
// ---------------------------------------------------------------------------
// par2ser_pkg
//   Shared definitions for the byte serializer and its future deserializer
//   counterpart: idle/comma character, sync preamble length, frame length,
//   FSM state type and the parity helper.
//
//   Build option: PAR2SER_PARITY_EN
//     undefined -> 8-bit frames, no parity
//     defined   -> 9-bit frames, ninth bit is even parity of the byte
// ---------------------------------------------------------------------------
package par2ser_pkg;

   localparam logic [7:0]  IDLE_CHAR_DEF   = 8'hBC;
   localparam int unsigned SYNC_FRAMES_DEF = 4;

`ifdef PAR2SER_PARITY_EN
   localparam int unsigned FRAME_LEN = 9;
`else
   localparam int unsigned FRAME_LEN = 8;
`endif

   // Bit counter covers 0..FRAME_LEN-1; sync counter covers 0..15.
   localparam int unsigned       CNT_W    = 4;
   localparam int unsigned       SYNC_W   = 4;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   // Even parity bit: makes the total count of ones (byte + bit) even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/par_to_serial_if.sv
// ---------------------------------------------------------------------------
// par_to_serial_if
//   Byte-in / bit-out bundle of the serializer.
//     data_in[7:0] : byte from upstream mux
//     valid_in     : qualifies data_in at a load edge
//     data_out     : serial bit, MSB first
//     frame_start  : high while the first bit of a frame is on data_out
//     load_ack     : one-cycle pulse after a valid byte was captured
//     active       : sync preamble complete
//   master = upstream source / observer, slave = serializer.
// ---------------------------------------------------------------------------
interface par_to_serial_if;

   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       frame_start;
   logic       load_ack;
   logic       active;

   modport master (
      output data_in, valid_in,
      input  data_out, frame_start, load_ack, active
   );

   modport slave (
      input  data_in, valid_in,
      output data_out, frame_start, load_ack, active
   );

endinterface

// File: rtl/frame_counter.sv
// ---------------------------------------------------------------------------
// frame_counter
//   Free-running bit position counter 0..FRAME_LEN-1, shared framing logic
//   for serializer and deserializer.
//     clk         : bit clock
//     rst         : asynchronous, active-high
//     load_edge   : high while the counter sits on the last bit, i.e. the
//                   next rising edge starts a new frame
//     frame_start : registered, high while bit 0 of a frame is on the line
//   The counter resets to the last position so the first edge after reset
//   release is a load edge. Frame length follows PAR2SER_PARITY_EN.
// ---------------------------------------------------------------------------
module frame_counter
   import par2ser_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic load_edge,
   output logic frame_start
);

   logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
   logic             frame_start_d, frame_start_q;

   assign load_edge   = (bit_cnt_q == LAST_BIT);
   assign frame_start = frame_start_q;

   always_comb begin
      // NOTE: combinational outputs get a default first; any path that
      // skipped an assignment would otherwise infer a latch.
      bit_cnt_d     = bit_cnt_q + 1'b1;
      if (load_edge) begin
         bit_cnt_d = '0;
      end
      frame_start_d = (bit_cnt_d == '0);
   end

   // NOTE: clocked state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q     <= LAST_BIT;
         frame_start_q <= 1'b0;
      end else begin
         bit_cnt_q     <= bit_cnt_d;
         frame_start_q <= frame_start_d;
      end
   end

endmodule

// File: rtl/par_to_serial.sv
// ---------------------------------------------------------------------------
// par_to_serial
//   Byte serializer on clk8f. Each frame carries one byte MSB first; idle
//   character IDLE_CHAR fills frames with no valid byte. After reset,
//   SYNC_FRAMES idle frames are sent unconditionally so the receiver can
//   align, then the block enters ACTIVE for good.
//     clk8f  : bit clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : par_to_serial_if.slave (data_in, valid_in -> data_out,
//              frame_start, load_ack, active)
//   Build option PAR2SER_PARITY_EN appends an even-parity ninth bit.
// ---------------------------------------------------------------------------
module par_to_serial
   import par2ser_pkg::*;
#(
   parameter logic [7:0]  IDLE_CHAR   = IDLE_CHAR_DEF,
   parameter int unsigned SYNC_FRAMES = SYNC_FRAMES_DEF
) (
   input  logic           clk8f,
   input  logic           reset,
   par_to_serial_if.slave bus
);

   localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_FRAMES - 1);

   state_e            state_d, state_q;
   logic [SYNC_W-1:0] sync_cnt_d, sync_cnt_q;
   logic [7:0]        shreg_d, shreg_q;
   logic              load_ack_d, load_ack_q;
   logic              load_edge;
   logic              frame_start;
`ifdef PAR2SER_PARITY_EN
   logic              parity_d, parity_q;
`endif

   frame_counter u_frame_counter (
      .clk         (clk8f),
      .rst         (reset),
      .load_edge   (load_edge),
      .frame_start (frame_start)
   );

   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      shreg_d    = {shreg_q[6:0], 1'b0};
      load_ack_d = 1'b0;
`ifdef PAR2SER_PARITY_EN
      parity_d   = parity_q;
`endif
      if (load_edge) begin
         shreg_d = IDLE_CHAR;
         if (state_q == SYNC) begin
            // Preamble: payload ignored; the last preamble frame is still idle.
            sync_cnt_d = sync_cnt_q + 1'b1;
            if (sync_cnt_q == LAST_SYNC) begin
               state_d = ACTIVE;
            end
         end else if (bus.valid_in) begin
            shreg_d    = bus.data_in;
            load_ack_d = 1'b1;
         end
`ifdef PAR2SER_PARITY_EN
         parity_d = even_parity(shreg_d);
`endif
      end
   end

   always_ff @(posedge clk8f or posedge reset) begin
      if (reset) begin
         state_q    <= SYNC;
         sync_cnt_q <= '0;
         shreg_q    <= 8'h00;
         load_ack_q <= 1'b0;
`ifdef PAR2SER_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
         shreg_q    <= shreg_d;
         load_ack_q <= load_ack_d;
`ifdef PAR2SER_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

`ifdef PAR2SER_PARITY_EN
   // The parity slot is the last bit position, which is exactly when the
   // counter reports the upcoming load edge; the shift register is empty then.
   assign bus.data_out = load_edge ? parity_q : shreg_q[7];
`else
   assign bus.data_out = shreg_q[7];
`endif
   assign bus.frame_start = frame_start;
   assign bus.load_ack    = load_ack_q;
   assign bus.active      = (state_q == ACTIVE);

endmodule

// File: tb/tb_par_to_serial.sv
// ---------------------------------------------------------------------------
// tb_par_to_serial
//   Self-checking bench for par_to_serial. A reference model derives every
//   output from the number of edges since reset release and the byte chosen
//   at each frame boundary; a compare process checks all outputs on every
//   falling edge. Directed frames pin the model against literal bit streams.
// ---------------------------------------------------------------------------
module tb_par_to_serial;
   import par2ser_pkg::*;

   localparam int         FL   = FRAME_LEN;
   localparam int         SYNC = 4;
   localparam logic [7:0] IDLE = 8'hBC;

`ifdef PAR2SER_PARITY_EN
   localparam logic [63:0] PRE_EXP  = 64'hB_CDE6_F379;   // 4 x 101111001
   localparam logic [63:0] A5_EXP   = 64'h14A;
   localparam logic [63:0] B2B_EXP  = 64'({9'h003, 9'h1FE, 9'h101});
   localparam logic [63:0] C3_EXP   = 64'h078;
   localparam logic [63:0] IDLE_EXP = 64'h179;
   localparam logic [63:0] F5A_EXP  = 64'h0B4;
`else
   localparam logic [63:0] PRE_EXP  = 64'hBCBC_BCBC;
   localparam logic [63:0] A5_EXP   = 64'hA5;
   localparam logic [63:0] B2B_EXP  = 64'h01_FF80;
   localparam logic [63:0] C3_EXP   = 64'h3C;
   localparam logic [63:0] IDLE_EXP = 64'hBC;
   localparam logic [63:0] F5A_EXP  = 64'h5A;
`endif

   logic clk8f = 1'b0;
   logic reset = 1'b0;

   par_to_serial_if bus ();

   par_to_serial #(
      .IDLE_CHAR   (IDLE),
      .SYNC_FRAMES (SYNC)
   ) dut (
      .clk8f (clk8f),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk8f = ~clk8f;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_n: edges since reset release (-1 while in reset); m_byte: byte of the
   // frame currently on the line; m_ack: a payload byte was taken last edge.
   int         m_n    = -1;
   logic [7:0] m_byte = 8'h00;
   logic       m_ack  = 1'b0;

   always @(posedge clk8f or posedge reset) begin
      if (reset) begin
         m_n    <= -1;
         m_byte <= 8'h00;
         m_ack  <= 1'b0;
      end else begin
         m_n   <= m_n + 1;
         m_ack <= 1'b0;
         if ((m_n + 1) % FL == 0) begin
            if ((m_n + 1) / FL >= SYNC && bus.valid_in) begin
               m_byte <= bus.data_in;
               m_ack  <= 1'b1;
            end else begin
               m_byte <= IDLE;
            end
         end
      end
   end

   function automatic logic exp_data_f(input int n, input logic [7:0] b);
      int pos;
      if (n < 0) return 1'b0;
      pos = n % FL;
      if (pos < 8) return b[7 - pos];
      return ^b;
   endfunction

   always @(negedge clk8f) begin
      check("data_out",    64'(bus.data_out),    64'(exp_data_f(m_n, m_byte)));
      check("frame_start", 64'(bus.frame_start), 64'(m_n >= 0 && m_n % FL == 0));
      check("load_ack",    64'(bus.load_ack),    64'(m_ack));
      check("active",      64'(bus.active),      64'(m_n >= 0 && m_n / FL >= SYNC - 1));
   end

   // ---------------- stimulus helpers ----------------
   // Called at a falling edge just before a load edge; returns one frame.
   task automatic frame(input logic v, input logic [7:0] d, input logic scramble,
                        output logic [8:0] bits, output logic fs0, output logic ack0);
      bus.valid_in = v;
      bus.data_in  = d;
      bits = '0;
      fs0  = 1'b0;
      ack0 = 1'b0;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk8f);
         bits = {bits[7:0], bus.data_out};
         if (i == 0) begin
            fs0  = bus.frame_start;
            ack0 = bus.load_ack;
         end
         if (scramble && i == 2) begin
            bus.valid_in = 1'($urandom);
            bus.data_in  = 8'($urandom);
         end
      end
   endtask

   // Called at the falling edge where reset was released.
   task automatic preamble(output logic [63:0] bits, output int acks,
                           output logic act_before, output logic act_after);
      bits = '0;
      acks = 0;
      act_before = 1'b1;
      act_after  = 1'b0;
      for (int i = 0; i < SYNC * FL; i++) begin
         @(negedge clk8f);
         bits = {bits[62:0], bus.data_out};
         acks += int'(bus.load_ack);
         if (i == (SYNC - 1) * FL - 1) act_before = bus.active;
         if (i == (SYNC - 1) * FL)     act_after  = bus.active;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] bits64;
      logic [63:0] cat;
      logic [8:0]  fb;
      logic        fs, ak, ab, aa;
      int          acks;
      int          ack_sum;

      bus.valid_in = 1'b0;
      bus.data_in  = 8'h00;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk8f);
      check("rst data_out",    64'(bus.data_out),    64'(0));
      check("rst frame_start", 64'(bus.frame_start), 64'(0));
      check("rst load_ack",    64'(bus.load_ack),    64'(0));
      check("rst active",      64'(bus.active),      64'(0));
      reset = 1'b0;

      // Sync preamble with no payload offered.
      preamble(bits64, acks, ab, aa);
      check("preamble stream", bits64, PRE_EXP);
      check("preamble acks",   64'(acks), 64'(0));
      check("active before last sync load", 64'(ab), 64'(0));
      check("active after last sync load",  64'(aa), 64'(1));

      // First payload byte.
      frame(1'b1, 8'hA5, 1'b0, fb, fs, ak);
      check("A5 frame", 64'(fb), A5_EXP);
      check("A5 frame_start", 64'(fs), 64'(1));
      check("A5 load_ack", 64'(ak), 64'(1));

      // Back-to-back payload bytes form one contiguous stream.
      cat = '0;
      ack_sum = 0;
      frame(1'b1, 8'h01, 1'b0, fb, fs, ak); cat = (cat << FL) | 64'(fb); ack_sum += int'(ak);
      frame(1'b1, 8'hFF, 1'b0, fb, fs, ak); cat = (cat << FL) | 64'(fb); ack_sum += int'(ak);
      frame(1'b1, 8'h80, 1'b0, fb, fs, ak); cat = (cat << FL) | 64'(fb); ack_sum += int'(ak);
      check("back-to-back stream", cat, B2B_EXP);
      check("back-to-back acks", 64'(ack_sum), 64'(3));

`ifdef PAR2SER_PARITY_EN
      frame(1'b1, 8'h03, 1'b0, fb, fs, ak);
      check("parity 03 frame", 64'(fb), 64'h006);
      frame(1'b1, 8'h07, 1'b0, fb, fs, ak);
      check("parity 07 frame", 64'(fb), 64'h00F);
`endif

      // Inputs disturbed mid-frame must not affect the frame in flight.
      frame(1'b1, 8'h3C, 1'b1, fb, fs, ak);
      check("mid-frame toggle frame", 64'(fb), C3_EXP);
      frame(1'b0, 8'h55, 1'b0, fb, fs, ak);
      check("idle after toggle", 64'(fb), IDLE_EXP);
      check("idle load_ack", 64'(ak), 64'(0));

      // Randomized traffic; the compare process checks every cycle.
      repeat (150) begin
         frame(1'($urandom), 8'($urandom), 1'($urandom), fb, fs, ak);
         check("random frame_start", 64'(fs), 64'(1));
      end

      // Reset in the middle of an A5 frame while a one is on the line.
      bus.valid_in = 1'b1;
      bus.data_in  = 8'hA5;
      repeat (5) @(negedge clk8f);
      @(posedge clk8f);
      #1;
      check("pre-reset bit", 64'(bus.data_out), 64'(1));
      #1 reset = 1'b1;
      #1;
      check("async rst data_out", 64'(bus.data_out), 64'(0));
      check("async rst active",   64'(bus.active),   64'(0));
      check("async rst frame_start", 64'(bus.frame_start), 64'(0));
      bus.valid_in = 1'b1;
      bus.data_in  = 8'h11;
      repeat (2) @(negedge clk8f);
      reset = 1'b0;
      preamble(bits64, acks, ab, aa);
      check("re-sync stream", bits64, PRE_EXP);
      check("re-sync acks",   64'(acks), 64'(0));
      check("re-sync active", 64'(aa), 64'(1));
      frame(1'b1, 8'h5A, 1'b0, fb, fs, ak);
      check("post re-sync frame", 64'(fb), F5A_EXP);
      check("post re-sync ack",   64'(ak), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
